riscv_axil_reg_slave: RTL
=========================

// Module: riscv_axil_reg_slave
// PURPOSE
//  AXI4-Lite responder exposing NUM_REGS 32-bit read/write control registers to the PS/AXI master.
//  Sits at the S00_AXI port of the RISC-V wrapper, between the AXI interconnect and the core's control inputs.
//  Handles independent AW/W arrival, byte strobes, backpressure on B/R and error response for unmapped words.
//  Drives register contents and per-register write pulses to the core.
// PARAMETERS
//  DATA_W     32   AXI data width; only 32 is supported.
//  ADDR_W     6    AXI address width; word index = ADDR[ADDR_W-1:2], ADDR[1:0] ignored.
//  NUM_REGS   4    implemented registers at word indices 0..NUM_REGS-1 (2..2**(ADDR_W-2)).
//  RESET_VAL  0    reset value of every register.
// PORTS
//  ACLK           in   1            clock; all logic on rising edge.
//  ARESETN        in   1            asynchronous active-low reset.
//  S_AXI_AWADDR   in   ADDR_W       write address.
//  S_AXI_AWPROT   in   3            ignored.
//  S_AXI_AWVALID  in   1            write address valid.
//  S_AXI_AWREADY  out  1            write address ready.
//  S_AXI_WDATA    in   32           write data.
//  S_AXI_WSTRB    in   4            byte enables.
//  S_AXI_WVALID   in   1            write data valid.
//  S_AXI_WREADY   out  1            write data ready.
//  S_AXI_BRESP    out  2            OKAY=2'b00, SLVERR=2'b10.
//  S_AXI_BVALID   out  1            write response valid.
//  S_AXI_BREADY   in   1            write response ready.
//  S_AXI_ARADDR   in   ADDR_W       read address.
//  S_AXI_ARPROT   in   3            ignored.
//  S_AXI_ARVALID  in   1            read address valid.
//  S_AXI_ARREADY  out  1            read address ready.
//  S_AXI_RDATA    out  32           read data.
//  S_AXI_RRESP    out  2            OKAY / SLVERR.
//  S_AXI_RVALID   out  1            read data valid.
//  S_AXI_RREADY   in   1            read data ready.
//  reg_q          out  NUM_REGS*32  register contents, reg i at [32*i+:32].
//  reg_wr_pulse   out  NUM_REGS     1-cycle pulse on the cycle after reg i is written (any strobe).
// BEHAVIOUR
//  Reset: all VALID/READY outputs 0; BRESP, RRESP, RDATA 0; regs = RESET_VAL; reg_wr_pulse 0. Mid-transaction reset aborts it, no response.
//  Write path, states W_IDLE / W_RESP:
//   - AWREADY = !aw_held && !BVALID; WREADY = !w_held && !BVALID (registered, 1 after reset release).
//   - AW and W are captured independently in any order/cycle; each holder clears only when the write commits.
//   - Commit on the first edge where both are held, or both handshake together (same edge possible): apply
//     WSTRB byte-wise to reg[idx], set BVALID=1 with BRESP; next state W_RESP. Latency: BVALID 1 cycle after last of AW/W.
//   - idx >= NUM_REGS: no register change, no pulse, BRESP=SLVERR.
//   - W_RESP: hold BVALID/BRESP stable until BREADY; on handshake BVALID=0, return to W_IDLE; READYs reassert next cycle.
//   - WSTRB=4'b0000 to a valid idx: BRESP=OKAY, data unchanged, pulse still issued.
//  Read path, states R_IDLE / R_DATA:
//   - ARREADY = !RVALID. On AR handshake, RDATA/RRESP registered, RVALID=1 next cycle.
//   - RDATA = reg[idx] as of the handshake edge (a write committing on the same edge is NOT visible).
//   - idx >= NUM_REGS: RDATA=0, RRESP=SLVERR.
//   - Hold RDATA/RRESP/RVALID stable until RREADY; then RVALID=0, ARREADY=1 next cycle. Max throughput: 1 read per 2 cycles.
//  Read and write paths are fully independent; no ordering between them.
// TESTING
//  1. Release reset; read 0x0,0x4,0x8,0xC -> RDATA 0, RRESP OKAY; reg_q all 0.
//  2. Write 1,2,3,4 to 0x0..0xC with BREADY=1, read back -> 1,2,3,4 OKAY; reg_wr_pulse bits 0..3 each one cycle.
//  3. Write 0xAABBCCDD to 0x4 then 0x11223344 with WSTRB=4'b0101 -> read 0x4 = 0xAA22CC44.
//  4. W 3 cycles before AW, then AW 3 cycles before W, BREADY low 5 cycles -> one BVALID each, stable while stalled, data correct.
//  5. Write/read 0x10 (idx 4) -> BRESP=SLVERR, RDATA=0 RRESP=SLVERR; regs 0..3 unchanged.
//  6. Deassert ARESETN with BVALID and RVALID pending -> both drop at once; regs back to RESET_VAL; new write works after release.

Source files
------------

// File: rtl/riscv_axil_reg_slave.sv
`timescale 1ns/1ps
// AXI4-Lite slave exposing NUM_REGS 32-bit control registers and per-register write pulses.
// The write and read channels are independent two-state machines; AW and W may arrive in any order.
module riscv_axil_reg_slave #(
   parameter int          DATA_W    = 32,
   parameter int          ADDR_W    = 6,
   parameter int          NUM_REGS  = 4,
   parameter logic [31:0] RESET_VAL = 32'h0000_0000
) (
   input  logic                     ACLK,
   input  logic                     ARESETN,
   input  logic [ADDR_W-1:0]        S_AXI_AWADDR,
   input  logic [2:0]               S_AXI_AWPROT,
   input  logic                     S_AXI_AWVALID,
   output logic                     S_AXI_AWREADY,
   input  logic [DATA_W-1:0]        S_AXI_WDATA,
   input  logic [DATA_W/8-1:0]      S_AXI_WSTRB,
   input  logic                     S_AXI_WVALID,
   output logic                     S_AXI_WREADY,
   output logic [1:0]               S_AXI_BRESP,
   output logic                     S_AXI_BVALID,
   input  logic                     S_AXI_BREADY,
   input  logic [ADDR_W-1:0]        S_AXI_ARADDR,
   input  logic [2:0]               S_AXI_ARPROT,
   input  logic                     S_AXI_ARVALID,
   output logic                     S_AXI_ARREADY,
   output logic [DATA_W-1:0]        S_AXI_RDATA,
   output logic [1:0]               S_AXI_RRESP,
   output logic                     S_AXI_RVALID,
   input  logic                     S_AXI_RREADY,
   output logic [NUM_REGS*DATA_W-1:0] reg_q,
   output logic [NUM_REGS-1:0]      reg_wr_pulse
);
   localparam int              IDX_W       = ADDR_W - 2;
   localparam int              STRB_W      = DATA_W / 8;
   localparam logic [IDX_W:0]  NUM_REGS_W  = (IDX_W + 1)'(NUM_REGS);
   localparam logic [1:0]      RESP_OKAY   = 2'b00;
   localparam logic [1:0]      RESP_SLVERR = 2'b10;

   typedef enum logic {W_IDLE = 1'b0, W_RESP = 1'b1} w_state_e;
   typedef enum logic {R_IDLE = 1'b0, R_DATA = 1'b1} r_state_e;

   function automatic logic [DATA_W-1:0] merge_strb(input logic [DATA_W-1:0] old_v,
                                                    input logic [DATA_W-1:0] new_v,
                                                    input logic [STRB_W-1:0] strb);
      logic [DATA_W-1:0] res;
      res = old_v;
      for (int b = 0; b < STRB_W; b++) begin
         if (strb[b]) begin
            res[8*b +: 8] = new_v[8*b +: 8];
         end else begin
            res[8*b +: 8] = old_v[8*b +: 8];
         end
      end
      return res;
   endfunction

   w_state_e            w_state_q, w_state_d;
   r_state_e            r_state_q, r_state_d;
   logic                aw_held_q, aw_held_d, w_held_q, w_held_d;
   logic [IDX_W-1:0]    aw_idx_q, aw_idx_d;
   logic [DATA_W-1:0]   w_data_q, w_data_d;
   logic [STRB_W-1:0]   w_strb_q, w_strb_d;
   logic [1:0]          bresp_q, bresp_d, rresp_q, rresp_d;
   logic                awready_q, awready_d, wready_q, wready_d, arready_q, arready_d;
   logic [DATA_W-1:0]   rdata_q, rdata_d;
   logic [DATA_W-1:0]   regs_q [NUM_REGS];
   logic [DATA_W-1:0]   regs_d [NUM_REGS];
   logic [NUM_REGS-1:0] pulse_q, pulse_d;

   logic                aw_hs_s, w_hs_s, commit_s, wr_hit_s, rd_hit_s;
   logic [IDX_W-1:0]    wr_idx_s, rd_idx_s;
   logic [DATA_W-1:0]   wr_data_s, rd_sel_s;
   logic [STRB_W-1:0]   wr_strb_s;
   logic                unused_s;

   assign unused_s = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};

   // Write channel: capture AW/W independently, commit once both are present, then hold B.
   always_comb begin
      aw_hs_s   = S_AXI_AWVALID && awready_q;
      w_hs_s    = S_AXI_WVALID && wready_q;
      wr_idx_s  = aw_held_q ? aw_idx_q : S_AXI_AWADDR[ADDR_W-1:2];
      wr_data_s = w_held_q ? w_data_q : S_AXI_WDATA;
      wr_strb_s = w_held_q ? w_strb_q : S_AXI_WSTRB;
      wr_hit_s  = ({1'b0, wr_idx_s} < NUM_REGS_W);
      commit_s  = 1'b0;
      w_state_d = w_state_q;
      aw_held_d = aw_held_q;
      aw_idx_d  = aw_idx_q;
      w_held_d  = w_held_q;
      w_data_d  = w_data_q;
      w_strb_d  = w_strb_q;
      bresp_d   = bresp_q;
      case (w_state_q)
         W_IDLE: begin
            if ((aw_held_q || aw_hs_s) && (w_held_q || w_hs_s)) begin
               commit_s  = 1'b1;
               aw_held_d = 1'b0;
               w_held_d  = 1'b0;
               bresp_d   = wr_hit_s ? RESP_OKAY : RESP_SLVERR;
               w_state_d = W_RESP;
            end else begin
               if (aw_hs_s) begin
                  aw_held_d = 1'b1;
                  aw_idx_d  = S_AXI_AWADDR[ADDR_W-1:2];
               end else begin
                  aw_held_d = aw_held_q;
               end
               if (w_hs_s) begin
                  w_held_d = 1'b1;
                  w_data_d = S_AXI_WDATA;
                  w_strb_d = S_AXI_WSTRB;
               end else begin
                  w_held_d = w_held_q;
               end
            end
         end
         W_RESP: begin
            if (S_AXI_BREADY) begin
               w_state_d = W_IDLE;
            end else begin
               w_state_d = W_RESP;
            end
         end
         default: w_state_d = W_IDLE;
      endcase
      for (int i = 0; i < NUM_REGS; i++) begin
         if (commit_s && (wr_idx_s == IDX_W'(i))) begin
            regs_d[i]  = merge_strb(regs_q[i], wr_data_s, wr_strb_s);
            pulse_d[i] = 1'b1;
         end else begin
            regs_d[i]  = regs_q[i];
            pulse_d[i] = 1'b0;
         end
      end
      awready_d = !aw_held_d && (w_state_d == W_IDLE);
      wready_d  = !w_held_d && (w_state_d == W_IDLE);
   end

   // Read channel: register the selected word on AR handshake and hold it until R handshake.
   always_comb begin
      rd_idx_s  = S_AXI_ARADDR[ADDR_W-1:2];
      rd_hit_s  = ({1'b0, rd_idx_s} < NUM_REGS_W);
      rd_sel_s  = '0;
      for (int i = 0; i < NUM_REGS; i++) begin
         if (rd_idx_s == IDX_W'(i)) begin
            rd_sel_s = regs_q[i];
         end else begin
            rd_sel_s = rd_sel_s;
         end
      end
      r_state_d = r_state_q;
      rdata_d   = rdata_q;
      rresp_d   = rresp_q;
      case (r_state_q)
         R_IDLE: begin
            if (S_AXI_ARVALID && arready_q) begin
               r_state_d = R_DATA;
               rdata_d   = rd_sel_s;
               rresp_d   = rd_hit_s ? RESP_OKAY : RESP_SLVERR;
            end else begin
               r_state_d = R_IDLE;
            end
         end
         R_DATA: begin
            if (S_AXI_RREADY) begin
               r_state_d = R_IDLE;
            end else begin
               r_state_d = R_DATA;
            end
         end
         default: r_state_d = R_IDLE;
      endcase
      arready_d = (r_state_d == R_IDLE);
   end

   // State and register file flops.
   always_ff @(posedge ACLK or negedge ARESETN) begin
      if (!ARESETN) begin
         w_state_q <= W_IDLE;
         r_state_q <= R_IDLE;
         aw_held_q <= 1'b0;
         aw_idx_q  <= '0;
         w_held_q  <= 1'b0;
         w_data_q  <= '0;
         w_strb_q  <= '0;
         bresp_q   <= 2'b00;
         rresp_q   <= 2'b00;
         rdata_q   <= '0;
         awready_q <= 1'b0;
         wready_q  <= 1'b0;
         arready_q <= 1'b0;
         pulse_q   <= '0;
         for (int i = 0; i < NUM_REGS; i++) begin
            regs_q[i] <= RESET_VAL;
         end
      end else begin
         w_state_q <= w_state_d;
         r_state_q <= r_state_d;
         aw_held_q <= aw_held_d;
         aw_idx_q  <= aw_idx_d;
         w_held_q  <= w_held_d;
         w_data_q  <= w_data_d;
         w_strb_q  <= w_strb_d;
         bresp_q   <= bresp_d;
         rresp_q   <= rresp_d;
         rdata_q   <= rdata_d;
         awready_q <= awready_d;
         wready_q  <= wready_d;
         arready_q <= arready_d;
         pulse_q   <= pulse_d;
         for (int i = 0; i < NUM_REGS; i++) begin
            regs_q[i] <= regs_d[i];
         end
      end
   end

   for (genvar g = 0; g < NUM_REGS; g++) begin : g_reg_out
      assign reg_q[DATA_W*g +: DATA_W] = regs_q[g];
   end

   assign S_AXI_AWREADY = awready_q;
   assign S_AXI_WREADY  = wready_q;
   assign S_AXI_BVALID  = (w_state_q == W_RESP);
   assign S_AXI_BRESP   = bresp_q;
   assign S_AXI_ARREADY = arready_q;
   assign S_AXI_RVALID  = (r_state_q == R_DATA);
   assign S_AXI_RDATA   = rdata_q;
   assign S_AXI_RRESP   = rresp_q;
   assign reg_wr_pulse  = pulse_q;

endmodule
